// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types, constants and round-robin helper for mem_arb_ram
//   Holds the default port request layout, byte count, stall saturation value
//   and the next-pointer function used by rr_arbiter.
package mem_arb_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF = 12;
    localparam int BYTES          = DATA_WIDTH_DEF / 8;
    localparam logic [15:0] STALL_MAX = 16'hFFFF;

    // Wide enough for up to 8 requesters.
    localparam int PTR_W = 3;

    typedef struct packed {
        logic                      wr_en;
        logic [ADDR_WIDTH_DEF-1:0] addr;
        logic [DATA_WIDTH_DEF-1:0] wdata;
        logic [BYTES-1:0]          be;
    } port_req_t;

    // Priority moves to the port just after the one granted, with wrap.
    function automatic logic [PTR_W-1:0] rr_next_ptr(input logic [PTR_W-1:0] granted,
                                                     input int num_ports);
        int n;
        n = int'(granted) + 1;
        if (n >= num_ports) begin
            n = 0;
        end
        return PTR_W'(n);
    endfunction

endpackage

// File: rtl/mem_arb_rr_arbiter.sv
// rtl/mem_arb_rr_arbiter.sv - round-robin arbiter with registered priority pointer
//   clk_i, rst_i : clock, synchronous active-high reset
//   req_i        : per-port requests
//   ptr_i        : current priority pointer (port searched first)
//   gnt_o        : one-hot grant, zero while in reset or idle
//   ptr_o        : registered next pointer, held when nothing is granted
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PTR_W-1:0]     ptr_i,
    output logic [NUM_PORTS-1:0] gnt_o,
    output logic [PTR_W-1:0]     ptr_o
);

    logic                 found;
    logic [PTR_W-1:0]     gidx;
    logic [NUM_PORTS-1:0] req_sh;
    int                   idx;
    logic [PTR_W-1:0]     ptr_q;

    // Search upward from ptr_i with wrap; first requester wins.
    always_comb begin
        gnt_o  = '0;
        found  = 1'b0;
        gidx   = '0;
        req_sh = '0;
        idx    = 0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr_i) + i;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            req_sh = req_i >> idx;
            if (!found && !rst_i && req_sh[0]) begin
                found = 1'b1;
                gnt_o = NUM_PORTS'(1) << idx;
                gidx  = PTR_W'(idx);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else if (found) begin
            ptr_q <= rr_next_ptr(gidx, NUM_PORTS);
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/mem_arb_ram.sv
// rtl/mem_arb_ram.sv - single-clock RAM shared by NUM_PORTS requesters via round-robin
//   clk_i, rst_i  : clock, synchronous active-high reset
//   req_i/wr_en_i/addr_i/wdata_i/be_i : per-port request fields (flattened, port 0 in LSBs)
//   gnt_o         : combinational one-hot grant
//   rvalid_o      : per-port read data valid, one cycle after read grant
//   rdata_o       : shared read data
//   err_o         : per-port out-of-range pulse, one cycle after the grant
//   stall_cnt_o   : saturating count of cycles with a denied request
module mem_arb_ram
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MEM_DEPTH  = 4096,
    parameter int NUM_PORTS  = 2,
    parameter int ADDR_WIDTH = $clog2(MEM_DEPTH)
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_PORTS-1:0]              req_i,
    input  logic [NUM_PORTS-1:0]              wr_en_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    output logic [DATA_WIDTH-1:0]             rdata_o,
    output logic [NUM_PORTS-1:0]              err_o,
    output logic [15:0]                       stall_cnt_o
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] ram [MEM_DEPTH];

    logic [NUM_PORTS-1:0]  gnt;
    logic [PTR_W-1:0]      ptr;

    logic                  any_gnt;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [NB-1:0]         sel_be;
    logic                  in_range;
    logic [3:0]            n_req;
    logic [3:0]            n_gnt;

    logic [NUM_PORTS-1:0]  rvalid_q;
    logic [NUM_PORTS-1:0]  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [15:0]           stall_q;
    logic [15:0]           stall_d;

    rr_arbiter #(
        .NUM_PORTS (NUM_PORTS)
    ) u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_i),
        .ptr_i (ptr),
        .gnt_o (gnt),
        .ptr_o (ptr)
    );

    // Route the granted port's fields to the single memory access path.
    always_comb begin
        any_gnt   = |gnt;
        sel_wr    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_be    = '0;
        n_req     = '0;
        n_gnt     = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            n_req = n_req + 4'(req_i[p]);
            n_gnt = n_gnt + 4'(gnt[p]);
            if (gnt[p]) begin
                sel_wr    = wr_en_i[p];
                sel_addr  = addr_i[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
                sel_be    = be_i[p*NB +: NB];
            end
        end
        // ADDR_WIDTH can reach beyond MEM_DEPTH when depth is not a power of two.
        in_range = (int'(sel_addr) < MEM_DEPTH);
    end

    always_comb begin
        stall_d = stall_q;
        if ((n_req > n_gnt) && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && any_gnt && sel_wr && in_range) begin
            for (int k = 0; k < NB; k++) begin
                if (sel_be[k]) begin
                    ram[sel_addr][8*k +: 8] <= sel_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            err_q    <= '0;
            rdata_q  <= '0;
            stall_q  <= '0;
        end else begin
            rvalid_q <= gnt & ~wr_en_i;
            err_q    <= in_range ? '0 : gnt;
            stall_q  <= stall_d;
            if (any_gnt && !sel_wr) begin
                rdata_q <= in_range ? ram[sel_addr] : '0;
            end
        end
    end

    // Outputs are forced low during reset so a read granted just before
    // reset never surfaces.
    assign gnt_o       = gnt;
    assign rvalid_o    = rst_i ? '0 : rvalid_q;
    assign err_o       = rst_i ? '0 : err_q;
    assign rdata_o     = rst_i ? '0 : rdata_q;
    assign stall_cnt_o = stall_q;

endmodule

// File: doc/mem_arb_ram.md
# mem_arb_ram

Parametrised single-clock RAM shared by NUM_PORTS requesters through a round-robin arbiter. It is the successor to the single-port 16-bit CPU memory. Typical use is the CPU on port 0 plus a program loader or debug master on port 1, in place of bench-side direct array loading. It adds byte-enable writes, out-of-range detection, per-port read-valid signalling and a saturating contention counter.

## Interface
- DATA_WIDTH, 16, word width in bits; multiple of 8
- MEM_DEPTH, 4096, number of words; need not be a power of two
- NUM_PORTS, 2, number of requesters, 1..8
- ADDR_WIDTH, $clog2(MEM_DEPTH), word address width
- clk_i  in  1  single clock; all logic on the rising edge
- rst_i  in  1  synchronous, active-high reset
- req_i  in  NUM_PORTS  per-port access request; held until granted
- wr_en_i  in  NUM_PORTS  per-port: 1 = write, 0 = read
- addr_i  in  NUM_PORTS×ADDR_WIDTH  per-port word address
- wdata_i  in  NUM_PORTS×DATA_WIDTH  per-port write data
- be_i  in  NUM_PORTS×DATA_WIDTH/8  per-port byte enables; bit k enables byte k
- gnt_o  out  NUM_PORTS  one-hot or zero; combinational grant in the cycle the request is accepted
- rvalid_o  out  NUM_PORTS  read data valid for that port, one cycle after its read grant
- rdata_o  out  DATA_WIDTH  shared read data, qualified by rvalid_o
- err_o  out  NUM_PORTS  one-cycle pulse one cycle after a granted access with addr_i ≥ MEM_DEPTH
- stall_cnt_o  out  16  saturating count of cycles in which at least one request was denied

## Operation
- The arbiter accepts at most one access per cycle. gnt_o[p] = 1 means the port's addr, wr_en, wdata and be are sampled at that edge.
- Round-robin: priority pointer ptr starts at port ptr and searches upward with wrap. After a grant to port p, ptr ← (p+1) mod NUM_PORTS. ptr is unchanged when nothing is granted.
- Write: for each k with be[k]=1, mem[addr][8k+7:8k] ← wdata[8k+7:8k]. Other bytes are kept. be = 0 is a legal no-op write and still consumes the grant.
- Read: rdata_o ← mem[addr] at the grant edge. rvalid_o[p] pulses high for exactly one cycle.
- rdata_o holds its last value when no rvalid_o is set.
- Out-of-range (addr ≥ MEM_DEPTH): a write is dropped and memory is unchanged. A read returns rdata_o = 0 with rvalid_o still asserted. err_o[p] pulses together with rvalid/the write-completion cycle.
- Write followed by a read to the same address in the next cycle returns the new data. No bypass is needed because the accesses are serialized.
- stall_cnt_o increments when popcount(req_i) > popcount(gnt_o), and saturates at 16'hFFFF.
- Reset values: ptr = 0, gnt_o is combinationally 0 while rst_i = 1, rvalid_o = 0, err_o = 0, rdata_o = 0, stall_cnt_o = 0. Memory contents are not reset.
- Reset mid-operation: a read granted in the cycle before rst_i produces no rvalid_o. A write on the edge with rst_i = 1 is not performed.

## Timing
- Grant latency: 0 cycles (same cycle as req_i, when the port has priority).
- Read latency: 1 cycle from grant edge to rvalid_o/rdata_o.
- Throughput: one access per cycle total. Under constant full contention each port is granted once every NUM_PORTS cycles.
- Requesters must not change their fields while req_i is high and ungranted. Dropping req_i before grant is allowed (request withdrawn).
- Back-to-back grants to the same port are allowed when it is the only requester.

## Structure
- Package mem_arb_pkg holds the following:
  - port request struct (wr_en, addr, wdata, be);
  - the localparams BYTES = DATA_WIDTH/8 and STALL_MAX = 16'hFFFF;
  - a function returning the round-robin next-pointer.
- Sub-module rr_arbiter (NUM_PORTS): inputs req, ptr; outputs one-hot gnt and registered next ptr. It is reused elsewhere for bus arbitration.
- The storage array is named ram so bench-side preload via hierarchical $fread keeps working.

## Test plan
- Reset: hold rst_i 2 cycles with req_i = 2'b11 → gnt_o = 0, rvalid_o = 0, stall_cnt_o = 0; the first grant after release goes to port 0.
- Byte enables: port 0 writes 16'hABCD to addr 5 with be = 2'b11, then 16'h1200 with be = 2'b10 → port 1 reads addr 5 → rdata_o = 16'h12CD with rvalid_o = 2'b10 one cycle after the grant.
- Contention: req_i = 2'b11 for 6 cycles, ports hold until granted and then re-request → grants alternate 0,1,0,1,0,1; stall_cnt_o = 6.
- Out-of-range: with MEM_DEPTH = 3000, read addr 3500 → rdata_o = 0, rvalid_o and err_o pulse. Write addr 3500 → no array word changes, err_o pulses.
- Reset mid-read: port 1 read granted at cycle n, rst_i = 1 at cycle n+1 → rvalid_o stays 0 and rdata_o = 0.
- Saturation: force continuous contention for 70000 cycles → stall_cnt_o = 16'hFFFF and does not wrap.
